// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared constants, state type and counter-width helper for the LFSR random source
package rng_pkg;

    localparam logic [31:0] RNG_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } rng_state_t;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int rng_cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rng_lfsr_step.sv
// rtl/rng_lfsr_step.sv - combinational Galois LFSR successor; RNG_ENTROPY_MIX_EN folds entropy_in into bit 31
module rng_lfsr_step
    import rng_pkg::*;
#(
    parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001
) (
    input  logic [31:0] state_in,
`ifdef RNG_ENTROPY_MIX_EN
    input  logic        entropy_in,
`endif
    output logic [31:0] state_out
);

    logic [31:0] shifted;
    logic [31:0] mixed;

    always_comb begin
        shifted = (state_in >> 1) ^ (state_in[0] ? RNG_POLY : 32'h0);
`ifdef RNG_ENTROPY_MIX_EN
        mixed = {shifted[31] ^ entropy_in, shifted[30:0]};
`else
        mixed = shifted;
`endif
        // The all-zero state is a lock-up point, so it is never allowed to escape.
        state_out = (mixed == 32'h0) ? SEED_DEFAULT : mixed;
    end

endmodule

// File: rtl/rng_lfsr_source.sv
// rtl/rng_lfsr_source.sv - divided, seeded, warmed-up LFSR word source for the random PIO; optional RNG_ENTROPY_MIX_EN
module rng_lfsr_source
    import rng_pkg::*;
#(
    parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001,
    parameter int unsigned UPDATE_DIV   = 1,
    parameter int unsigned WARMUP_STEPS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        seed_load,
    input  logic [31:0] seed_data,
`ifdef RNG_ENTROPY_MIX_EN
    input  logic        entropy_in,
`endif
    output logic [31:0] rand_out,
    output logic        rand_valid,
    output logic        sample_strobe
);

    localparam int DIV_W  = rng_cnt_width(int'(UPDATE_DIV) - 1);
    localparam int WARM_W = rng_cnt_width(int'(WARMUP_STEPS));
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(UPDATE_DIV - 1);
    localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(WARMUP_STEPS);
    localparam rng_state_t START_STATE = (WARMUP_STEPS == 0) ? RUN : WARMUP;

    rng_state_t        state_q, state_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [31:0]       rand_out_q, rand_out_d;
    logic              rand_valid_q, rand_valid_d;
    logic              sample_strobe_q, sample_strobe_d;

    logic [31:0] lfsr_next;
    logic        step_tick;

    rng_lfsr_step #(
        .SEED_DEFAULT(SEED_DEFAULT)
    ) u_step (
        .state_in  (lfsr_q),
`ifdef RNG_ENTROPY_MIX_EN
        .entropy_in(entropy_in),
`endif
        .state_out (lfsr_next)
    );

    assign step_tick = enable && (state_q != IDLE) && (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d         = state_q;
        lfsr_d          = lfsr_q;
        div_cnt_d       = div_cnt_q;
        warm_cnt_d      = warm_cnt_q;
        rand_out_d      = rand_out_q;
        rand_valid_d    = rand_valid_q;
        sample_strobe_d = 1'b0;

        // A seed load wins over a coincident step and restarts the warm-up.
        if (seed_load) begin
            lfsr_d       = (seed_data == 32'h0) ? SEED_DEFAULT : seed_data;
            div_cnt_d    = '0;
            warm_cnt_d   = WARM_INIT;
            rand_out_d   = 32'h0;
            rand_valid_d = 1'b0;
            state_d      = enable ? START_STATE : IDLE;
        end else if (enable) begin
            case (state_q)
                IDLE: begin
                    state_d = START_STATE;
                end
                WARMUP, RUN: begin
                    div_cnt_d = step_tick ? '0 : div_cnt_q + DIV_W'(1);
                    if (step_tick) begin
                        lfsr_d = lfsr_next;
                        if (state_q == WARMUP) begin
                            warm_cnt_d = warm_cnt_q - WARM_W'(1);
                        end
                        if (state_q == RUN || warm_cnt_q == WARM_W'(1)) begin
                            state_d         = RUN;
                            rand_out_d      = lfsr_next;
                            rand_valid_d    = 1'b1;
                            sample_strobe_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            lfsr_q          <= SEED_DEFAULT;
            div_cnt_q       <= '0;
            warm_cnt_q      <= WARM_INIT;
            rand_out_q      <= 32'h0;
            rand_valid_q    <= 1'b0;
            sample_strobe_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            lfsr_q          <= lfsr_d;
            div_cnt_q       <= div_cnt_d;
            warm_cnt_q      <= warm_cnt_d;
            rand_out_q      <= rand_out_d;
            rand_valid_q    <= rand_valid_d;
            sample_strobe_q <= sample_strobe_d;
        end
    end

    assign rand_out      = rand_out_q;
    assign rand_valid    = rand_valid_q;
    assign sample_strobe = sample_strobe_q;

endmodule
